// File: rtl/mips_multicycle_ctrl.sv
// Main control FSM for the multicycle MIPS core: sequences fetch/decode/execute/memory/writeback.
// Optional feature macro: JAL_EN adds the JAL state (opcode 000011 writes PC+4 to $ra and jumps).
module mips_multicycle_ctrl (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [5:0] Opcode,
   input  logic [5:0] Funct,
   input  logic       MemReady,
   output logic       IorD,
   output logic       MemWrite,
   output logic       IRWrite,
   output logic       PCWrite,
   output logic       Branch,
   output logic       BranchNe,
   output logic       RegWrite,
   output logic       ALUSrcA,
   output logic [1:0] RegDst,
   output logic [1:0] MemtoReg,
   output logic [1:0] ALUSrcB,
   output logic [1:0] PCSrc,
   output logic [2:0] ALUOp,
   output logic       IllegalOp
);

   typedef enum logic [3:0] {
      IDLE     = 4'd0,
      FETCH    = 4'd1,
      DECODE   = 4'd2,
      MEMADR   = 4'd3,
      MEMREAD  = 4'd4,
      MEMWB    = 4'd5,
      MEMWRITE = 4'd6,
      EXECUTE  = 4'd7,
      ALUWB    = 4'd8,
      BRANCH   = 4'd9,
      IMMEX    = 4'd10,
      IMMWB    = 4'd11,
      JUMP     = 4'd12,
      JR       = 4'd13,
      JAL      = 4'd14
   } state_t;

   typedef struct packed {
      logic       iorD;
      logic       memWrite;
      logic       pcWrite;
      logic       branch;
      logic       branchNe;
      logic       regWrite;
      logic       aluSrcA;
      logic [1:0] regDst;
      logic [1:0] memtoReg;
      logic [1:0] aluSrcB;
      logic [1:0] pcSrc;
      logic [2:0] aluOp;
   } ctrl_t;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_J     = 6'b000010;
   localparam logic [5:0] OP_JAL   = 6'b000011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_BNE   = 6'b000101;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_ANDI  = 6'b001100;
   localparam logic [5:0] OP_ORI   = 6'b001101;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] FN_JR    = 6'b001000;

   state_t state_q, state_d;
   ctrl_t  ctrl_q, ctrl_d;
   logic   illegal_q, illegal_d;
   logic   fetchGate;

   // Control word for a state; opcode-dependent fields use the IR, which is stable for the instruction.
   function automatic ctrl_t decodeCtrl(input state_t s, input logic [5:0] op);
      ctrl_t c;
      c = '0;
      case (s)
         FETCH:    c.aluSrcB = 2'b01;
         DECODE:   c.aluSrcB = 2'b11;
         MEMADR:   begin c.aluSrcA = 1'b1; c.aluSrcB = 2'b10; end
         MEMREAD:  c.iorD = 1'b1;
         MEMWB:    begin c.memtoReg = 2'b01; c.regWrite = 1'b1; end
         MEMWRITE: begin c.iorD = 1'b1; c.memWrite = 1'b1; end
         EXECUTE:  begin c.aluSrcA = 1'b1; c.aluOp = 3'b010; end
         ALUWB:    begin c.regDst = 2'b01; c.regWrite = 1'b1; end
         BRANCH: begin
            c.aluSrcA  = 1'b1;
            c.aluOp    = 3'b001;
            c.pcSrc    = 2'b01;
            c.branch   = (op == OP_BEQ);
            c.branchNe = (op == OP_BNE);
         end
         IMMEX: begin
            c.aluSrcA = 1'b1;
            c.aluSrcB = 2'b10;
            if (op == OP_ANDI)     c.aluOp = 3'b011;
            else if (op == OP_ORI) c.aluOp = 3'b100;
            else                   c.aluOp = 3'b000;
         end
         IMMWB:    c.regWrite = 1'b1;
         JUMP:     begin c.pcSrc = 2'b10; c.pcWrite = 1'b1; end
         JR:       begin c.aluSrcA = 1'b1; c.aluOp = 3'b010; c.pcWrite = 1'b1; end
`ifdef JAL_EN
         JAL: begin
            c.pcSrc    = 2'b10;
            c.pcWrite  = 1'b1;
            c.regDst   = 2'b10;
            c.memtoReg = 2'b10;
            c.regWrite = 1'b1;
         end
`endif
         default:  c = '0;
      endcase
      return c;
   endfunction

   // Next-state logic; an undecodable opcode returns to FETCH and flags IllegalOp for one cycle.
   always_comb begin
      state_d   = state_q;
      illegal_d = 1'b0;
      case (state_q)
         IDLE:     state_d = FETCH;
         FETCH:    if (MemReady) state_d = DECODE;
         DECODE: begin
            case (Opcode)
               OP_LW, OP_SW:               state_d = MEMADR;
               OP_RTYPE:                   state_d = EXECUTE;
               OP_BEQ, OP_BNE:             state_d = BRANCH;
               OP_ADDI, OP_ANDI, OP_ORI:   state_d = IMMEX;
               OP_J:                       state_d = JUMP;
`ifdef JAL_EN
               OP_JAL:                     state_d = JAL;
`endif
               default: begin
                  state_d   = FETCH;
                  illegal_d = 1'b1;
               end
            endcase
         end
         MEMADR:   state_d = (Opcode == OP_SW) ? MEMWRITE : MEMREAD;
         MEMREAD:  if (MemReady) state_d = MEMWB;
         MEMWRITE: if (MemReady) state_d = FETCH;
         EXECUTE:  state_d = (Funct == FN_JR) ? JR : ALUWB;
         IMMEX:    state_d = IMMWB;
         default:  state_d = FETCH;
      endcase
      ctrl_d = decodeCtrl(state_d, Opcode);
   end

   // Outputs are registered alongside the state so they decode the state the FSM is entering.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         ctrl_q    <= '0;
         illegal_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         ctrl_q    <= ctrl_d;
         illegal_q <= illegal_d;
      end
   end

   // The instruction fetch only commits in the cycle memory delivers the word.
   assign fetchGate = (state_q == FETCH) && MemReady;

   assign IorD      = ctrl_q.iorD;
   assign MemWrite  = ctrl_q.memWrite;
   assign IRWrite   = fetchGate;
   assign PCWrite   = ctrl_q.pcWrite | fetchGate;
   assign Branch    = ctrl_q.branch;
   assign BranchNe  = ctrl_q.branchNe;
   assign RegWrite  = ctrl_q.regWrite;
   assign ALUSrcA   = ctrl_q.aluSrcA;
   assign RegDst    = ctrl_q.regDst;
   assign MemtoReg  = ctrl_q.memtoReg;
   assign ALUSrcB   = ctrl_q.aluSrcB;
   assign PCSrc     = ctrl_q.pcSrc;
   assign ALUOp     = ctrl_q.aluOp;
   assign IllegalOp = illegal_q;

endmodule
